// File: rtl/line_builder_pkg.sv
// Shared constants, state encoding and sizing helper for the cache line builder.
package line_builder_pkg;

   localparam int CACHE_WORD_W     = 16;
   localparam int CACHE_LINE_WORDS = 4;
   localparam int CACHE_LINE_W     = CACHE_WORD_W * CACHE_LINE_WORDS;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   // Bits needed to address one word slot within a line.
   function automatic int slot_idx_w(input int words);
      return $clog2(words);
   endfunction

endpackage

// File: rtl/line_builder_if.sv
// Word-in / line-out bus of the line builder; the parity signals exist only
// when LINE_BUILDER_PARITY_EN is defined.
interface line_builder_if
   import line_builder_pkg::*;
#(
   parameter int WORD_W = CACHE_WORD_W,
   parameter int WORDS  = CACHE_LINE_WORDS
);
   localparam int LINE_W = WORD_W * WORDS;
   localparam int FC_W   = slot_idx_w(WORDS) + 1;

   logic              abort;
   logic [WORD_W-1:0] in_word;
   logic              in_valid;
   logic              in_ready;
   logic [LINE_W-1:0] line_out;
   logic              line_valid;
   logic              line_ready;
   logic [FC_W-1:0]   fill_count;
`ifdef LINE_BUILDER_PARITY_EN
   logic              in_parity;
   logic [WORDS-1:0]  line_parity;
   logic              parity_err;

   modport master (
      output abort, in_word, in_valid, line_ready, in_parity,
      input  in_ready, line_out, line_valid, fill_count, line_parity, parity_err
   );
   modport slave (
      input  abort, in_word, in_valid, line_ready, in_parity,
      output in_ready, line_out, line_valid, fill_count, line_parity, parity_err
   );
`else
   modport master (
      output abort, in_word, in_valid, line_ready,
      input  in_ready, line_out, line_valid, fill_count
   );
   modport slave (
      input  abort, in_word, in_valid, line_ready,
      output in_ready, line_out, line_valid, fill_count
   );
`endif

endinterface

// File: rtl/line_builder_parity_calc.sv
// Even parity (XOR reduction) of one incoming word.
module line_builder_parity_calc #(
   parameter int WORD_W = 16
) (
   input  logic [WORD_W-1:0] word,
   output logic              parity
);

   assign parity = ^word;

endmodule

// File: rtl/line_builder.sv
// Packs a stream of WORD_W-bit memory words into a WORDS-word cache line, bottom slot first.
// Optional per-slot parity tracking is enabled with LINE_BUILDER_PARITY_EN.
module line_builder
   import line_builder_pkg::*;
#(
   parameter int WORD_W = CACHE_WORD_W,
   parameter int WORDS  = CACHE_LINE_WORDS
) (
   input  logic          clk,
   input  logic          rst,
   line_builder_if.slave bus
);

   localparam int LINE_W = WORD_W * WORDS;
   localparam int SLOT_W = slot_idx_w(WORDS);
   localparam int FC_W   = SLOT_W + 1;

   state_t            state_reg;
   state_t            state_next;
   logic [FC_W-1:0]   fill_count_reg;
   logic [FC_W-1:0]   fill_count_next;
   logic [WORD_W-1:0] slot_reg [WORDS];
   logic [WORDS-1:0]  slot_we;
   logic [LINE_W-1:0] line_flat;
   logic [SLOT_W-1:0] slot_idx;
   logic              accept;
   logic              consume;

   // Abort suppresses the accept, so a word presented alongside it never lands.
   assign accept   = (state_reg == FILL) && bus.in_valid && !bus.abort;
   assign consume  = (state_reg == FULL) && bus.line_ready;
   assign slot_idx = fill_count_reg[SLOT_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= FILL;
         fill_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         fill_count_reg <= fill_count_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      fill_count_next = fill_count_reg;
      if (bus.abort) begin
         state_next      = FILL;
         fill_count_next = '0;
      end else begin
         case (state_reg)
            FILL: begin
               if (accept) begin
                  fill_count_next = fill_count_reg + FC_W'(1);
                  if (fill_count_reg == FC_W'(WORDS - 1)) begin
                     state_next = FULL;
                  end
               end
            end
            FULL: begin
               if (consume) begin
                  state_next      = FILL;
                  fill_count_next = '0;
               end
            end
            default: begin
               state_next      = FILL;
               fill_count_next = '0;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_slot
         assign slot_we[gi] = accept && (slot_idx == SLOT_W'(gi));
         assign line_flat[gi*WORD_W +: WORD_W] = slot_reg[gi];
      end
   endgenerate

   // Slots are never cleared on consume or abort; stale words are simply overwritten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WORDS; i++) begin
            slot_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WORDS; i++) begin
            if (slot_we[i]) begin
               slot_reg[i] <= bus.in_word;
            end
         end
      end
   end

   assign bus.in_ready   = (state_reg == FILL);
   assign bus.line_valid = (state_reg == FULL);
   assign bus.fill_count = fill_count_reg;
   assign bus.line_out   = line_flat;

`ifdef LINE_BUILDER_PARITY_EN
   logic             word_parity;
   logic [WORDS-1:0] line_parity_reg;
   logic             parity_err_reg;

   line_builder_parity_calc #(
      .WORD_W (WORD_W)
   ) u_parity_calc (
      .word   (bus.in_word),
      .parity (word_parity)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_parity_reg <= '0;
         parity_err_reg  <= 1'b0;
      end else if (bus.abort) begin
         line_parity_reg <= '0;
         parity_err_reg  <= 1'b0;
      end else begin
         for (int i = 0; i < WORDS; i++) begin
            if (slot_we[i]) begin
               line_parity_reg[i] <= word_parity;
            end
         end
         parity_err_reg <= accept && (bus.in_parity != word_parity);
      end
   end

   assign bus.line_parity = line_parity_reg;
   assign bus.parity_err  = parity_err_reg;
`endif

endmodule

// File: tb/tb_line_builder.sv
// Directed, table-driven bench for line_builder; parity checks run only with LINE_BUILDER_PARITY_EN.
module tb_line_builder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   line_builder_if #(.WORD_W(16), .WORDS(4)) bus ();

   line_builder #(.WORD_W(16), .WORDS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        ab;
      logic        v;
      logic [15:0] w;
      logic        lr;
      logic        ir;
      logic        lv;
      logic [2:0]  fc;
      logic [63:0] lo;
   } vec_t;

   vec_t vecs[$];
   int   compared   = 0;
   int   mismatched = 0;

   function automatic vec_t mk(input logic ab, input logic v, input logic [15:0] w,
                               input logic lr, input logic ir, input logic lv,
                               input logic [2:0] fc, input logic [63:0] lo);
      vec_t r;
      r.ab = ab; r.v = v; r.w = w; r.lr = lr;
      r.ir = ir; r.lv = lv; r.fc = fc; r.lo = lo;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ab, input logic v, input logic [15:0] w, input logic lr);
      bus.abort      = ab;
      bus.in_valid   = v;
      bus.in_word    = w;
      bus.line_ready = lr;
`ifdef LINE_BUILDER_PARITY_EN
      bus.in_parity  = ^w;
`endif
   endtask

   task automatic check_outs(input string tag, input logic ir, input logic lv,
                             input logic [2:0] fc, input logic [63:0] lo);
      check({tag, ".in_ready"},   64'(bus.in_ready),   64'(ir));
      check({tag, ".line_valid"}, 64'(bus.line_valid), 64'(lv));
      check({tag, ".fill_count"}, 64'(bus.fill_count), 64'(fc));
      check({tag, ".line_out"},   bus.line_out,        lo);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0000, 1'b0);
      #3;
      check_outs("reset", 1'b1, 1'b0, 3'd0, 64'h0);
`ifdef LINE_BUILDER_PARITY_EN
      check("reset.line_parity", 64'(bus.line_parity), 64'h0);
      check("reset.parity_err",  64'(bus.parity_err),  64'h0);
`endif
      @(negedge clk);
      rst = 1'b0;

      //                ab  v  word      lr  ir  lv  fc  line_out
      // basic fill
      vecs.push_back(mk(0, 1, 16'h1111, 0, 1, 0, 1, 64'h0000_0000_0000_1111));
      vecs.push_back(mk(0, 1, 16'h2222, 0, 1, 0, 2, 64'h0000_0000_2222_1111));
      vecs.push_back(mk(0, 1, 16'h3333, 0, 1, 0, 3, 64'h0000_3333_2222_1111));
      vecs.push_back(mk(0, 1, 16'h4444, 0, 0, 1, 4, 64'h4444_3333_2222_1111));
      // backpressure: new words offered but ignored
      vecs.push_back(mk(0, 1, 16'h5555, 0, 0, 1, 4, 64'h4444_3333_2222_1111));
      vecs.push_back(mk(0, 1, 16'h6666, 0, 0, 1, 4, 64'h4444_3333_2222_1111));
      vecs.push_back(mk(0, 1, 16'h7777, 0, 0, 1, 4, 64'h4444_3333_2222_1111));
      vecs.push_back(mk(0, 1, 16'h8888, 0, 0, 1, 4, 64'h4444_3333_2222_1111));
      vecs.push_back(mk(0, 1, 16'h9999, 0, 0, 1, 4, 64'h4444_3333_2222_1111));
      // consume; the word offered in the handshake cycle is not taken
      vecs.push_back(mk(0, 1, 16'h9998, 1, 1, 0, 0, 64'h4444_3333_2222_1111));
      // gapped input with garbage while invalid; line_ready ignored in FILL
      vecs.push_back(mk(0, 0, 16'hDEAD, 0, 1, 0, 0, 64'h4444_3333_2222_1111));
      vecs.push_back(mk(0, 1, 16'hAAA1, 0, 1, 0, 1, 64'h4444_3333_2222_AAA1));
      vecs.push_back(mk(0, 0, 16'hBEEF, 0, 1, 0, 1, 64'h4444_3333_2222_AAA1));
      vecs.push_back(mk(0, 1, 16'hAAA2, 0, 1, 0, 2, 64'h4444_3333_AAA2_AAA1));
      vecs.push_back(mk(0, 0, 16'hFFFF, 1, 1, 0, 2, 64'h4444_3333_AAA2_AAA1));
      vecs.push_back(mk(0, 1, 16'hAAA3, 0, 1, 0, 3, 64'h4444_AAA3_AAA2_AAA1));
      vecs.push_back(mk(0, 0, 16'hC0DE, 0, 1, 0, 3, 64'h4444_AAA3_AAA2_AAA1));
      vecs.push_back(mk(0, 1, 16'hAAA4, 0, 0, 1, 4, 64'hAAA4_AAA3_AAA2_AAA1));
      // abort together with line_ready while FULL drops the line
      vecs.push_back(mk(1, 1, 16'h1234, 1, 1, 0, 0, 64'hAAA4_AAA3_AAA2_AAA1));
      // two words, abort with a concurrent word, then a fresh line
      vecs.push_back(mk(0, 1, 16'hAAAA, 0, 1, 0, 1, 64'hAAA4_AAA3_AAA2_AAAA));
      vecs.push_back(mk(0, 1, 16'hBBBB, 0, 1, 0, 2, 64'hAAA4_AAA3_BBBB_AAAA));
      vecs.push_back(mk(1, 1, 16'hCCCC, 0, 1, 0, 0, 64'hAAA4_AAA3_BBBB_AAAA));
      vecs.push_back(mk(0, 1, 16'h0001, 0, 1, 0, 1, 64'hAAA4_AAA3_BBBB_0001));
      vecs.push_back(mk(0, 1, 16'h0002, 0, 1, 0, 2, 64'hAAA4_AAA3_0002_0001));
      vecs.push_back(mk(0, 1, 16'h0003, 0, 1, 0, 3, 64'hAAA4_0003_0002_0001));
      vecs.push_back(mk(0, 1, 16'h0004, 0, 0, 1, 4, 64'h0004_0003_0002_0001));
      vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 0, 64'h0004_0003_0002_0001));
      // abort in FILL with nothing held: no visible effect
      vecs.push_back(mk(1, 0, 16'h5A5A, 0, 1, 0, 0, 64'h0004_0003_0002_0001));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ab, vecs[i].v, vecs[i].w, vecs[i].lr);
         @(posedge clk);
         #1;
         $display("vec %0d: ab=%0b v=%0b w=%h lr=%0b -> ir=%0b lv=%0b fc=%0d lo=%h",
                  i, vecs[i].ab, vecs[i].v, vecs[i].w, vecs[i].lr,
                  bus.in_ready, bus.line_valid, bus.fill_count, bus.line_out);
         check_outs($sformatf("vec%0d", i), vecs[i].ir, vecs[i].lv, vecs[i].fc, vecs[i].lo);
      end

      // asynchronous reset between edges, mid-fill
      drive(1'b0, 1'b1, 16'h0A0A, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, 16'h0B0B, 1'b0);
      @(posedge clk);
      #2;
      check("premid.fill_count", 64'(bus.fill_count), 64'd2);
      drive(1'b0, 1'b0, 16'h0000, 1'b0);
      rst = 1'b1;
      #1;
      $display("async rst mid-fill -> ir=%0b lv=%0b fc=%0d lo=%h",
               bus.in_ready, bus.line_valid, bus.fill_count, bus.line_out);
      check_outs("arst", 1'b1, 1'b0, 3'd0, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      drive(1'b0, 1'b1, 16'h0007, 1'b0);
      @(posedge clk);
      #1;
      $display("post-reset accept -> fc=%0d lo=%h", bus.fill_count, bus.line_out);
      check_outs("postrst", 1'b1, 1'b0, 3'd1, 64'h0000_0000_0000_0007);

`ifdef LINE_BUILDER_PARITY_EN
      check("par.good_err", 64'(bus.parity_err), 64'h0);
      check("par.slot0", 64'(bus.line_parity), 64'h1);
      drive(1'b0, 1'b1, 16'h0001, 1'b0);
      bus.in_parity = 1'b0;
      @(posedge clk);
      #1;
      $display("bad parity accept -> err=%0b lp=%b", bus.parity_err, bus.line_parity);
      check("par.err_pulse", 64'(bus.parity_err), 64'h1);
      check("par.slot1", 64'(bus.line_parity), 64'h3);
      check("par.stored", bus.line_out, 64'h0000_0000_0001_0007);
      drive(1'b0, 1'b0, 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      check("par.err_clear", 64'(bus.parity_err), 64'h0);
      drive(1'b1, 1'b0, 16'h0000, 1'b0);
      @(posedge clk);
      #1;
      $display("abort -> lp=%b fc=%0d", bus.line_parity, bus.fill_count);
      check("par.abort_clear", 64'(bus.line_parity), 64'h0);
      drive(1'b0, 1'b0, 16'h0000, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
